// File: rtl/des_ctrl_pkg.sv
// des_ctrl_pkg: shared types and constants for the DES/SPI sequencer
package des_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_LOAD
    } state_t;

    localparam int DES_W = 64;
    localparam logic [DES_W-1:0] TIMEOUT_FILL = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: multi-flop synchroniser for an asynchronous level, preset on reset
module sync_2ff #(
    parameter int   SYNC_STAGES = 2,
    parameter logic INIT        = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] ff;

    // shift the pad level through the flop chain
    always_ff @(posedge clk) begin
        if (rst)
            ff <= {SYNC_STAGES{INIT}};
        else
            ff <= {ff[SYNC_STAGES-2:0], d};
    end

    assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/des_spi_ctrl.sv
// des_spi_ctrl: sequences SPI frames into key loads and DES operations
module des_spi_ctrl
    import des_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spi_cs_n,
    input  logic [DES_W-1:0] spi_rx_word,
    output logic [DES_W-1:0] spi_tx_word,
    input  logic             decrypt,
    input  logic             key_reload,
    output logic             des_start,
    output logic             des_decrypt,
    output logic [DES_W-1:0] des_key,
    output logic [DES_W-1:0] des_din,
    input  logic [DES_W-1:0] des_dout,
    input  logic             des_done,
    output logic             key_valid,
    output logic             busy,
    output logic             overrun,
    output logic             timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    state_t           state, state_n;
    logic             cs_s, cs_d, cs_rise, key_pending, hit, idle_rise;
    logic [CW-1:0]    cnt;
    logic [DES_W-1:0] result;

    sync_2ff #(.SYNC_STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (spi_cs_n),
        .q   (cs_s)
    );

    assign busy      = state != S_IDLE;
    assign hit       = cnt == CW'(TIMEOUT_CYCLES - 1);
    assign idle_rise = cs_rise && state == S_IDLE;

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // next state and the start strobe; a done coinciding with the timeout wins
    always_comb begin
        state_n   = state;
        des_start = 1'b0;
        unique case (state)
            S_IDLE:  state_n = (cs_rise && !key_pending) ? S_START : S_IDLE;
            S_START: begin
                des_start = 1'b1;
                state_n   = S_BUSY;
            end
            S_BUSY:  state_n = (des_done || hit) ? S_LOAD : S_BUSY;
            S_LOAD:  state_n = cs_s ? S_IDLE : S_LOAD;
        endcase
    end

    // frame capture, timeout counter, result and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            cs_d        <= 1'b1;
            cs_rise     <= 1'b0;
            key_pending <= 1'b1;
            key_valid   <= 1'b0;
            des_key     <= '0;
            des_din     <= '0;
            des_decrypt <= 1'b0;
            cnt         <= '0;
            result      <= '0;
            spi_tx_word <= '0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cs_d    <= cs_s;
            cs_rise <= cs_s && !cs_d;
            if (key_reload)
                key_pending <= 1'b1;
            else if (idle_rise && key_pending)
                key_pending <= 1'b0;
            if (idle_rise && key_pending) begin
                des_key   <= spi_rx_word;
                key_valid <= 1'b1;
            end
            if (idle_rise && !key_pending) begin
                des_din     <= spi_rx_word;
                des_decrypt <= decrypt;
            end
            if (cs_rise && state != S_IDLE)
                overrun <= 1'b1;
            cnt <= (state == S_BUSY) ? cnt + CW'(1) : '0;
            if (state == S_BUSY && des_done)
                result <= des_dout;
            else if (state == S_BUSY && hit) begin
                result      <= TIMEOUT_FILL;
                timeout_err <= 1'b1;
            end
            if (state == S_LOAD && cs_s)
                spi_tx_word <= result;
        end
    end

endmodule

// File: tb/tb_des_spi_ctrl.sv
// tb_des_spi_ctrl: scoreboard bench for the DES/SPI sequencer with a DES stub
module tb_des_spi_ctrl;
    import des_ctrl_pkg::*;

    typedef struct packed {
        logic [63:0] din;
        logic        dec;
        logic [63:0] key;
    } start_t;

    localparam logic [63:0] K1 = 64'h1334_5779_9BBC_DFF1;
    localparam logic [63:0] D1 = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] R1 = 64'h85E8_1354_0F0A_B405;
    localparam logic [63:0] D2 = 64'h1111_1111_1111_1111;
    localparam logic [63:0] R2 = 64'h2222_2222_2222_2222;
    localparam logic [63:0] D3 = 64'h3030_3030_3030_3030;
    localparam logic [63:0] R3 = 64'h3333_3333_3333_3333;
    localparam logic [63:0] D4 = 64'h4444_4444_4444_4444;
    localparam logic [63:0] R4 = 64'h5555_5555_5555_5555;
    localparam logic [63:0] D5 = 64'h6666_6666_6666_6666;
    localparam logic [63:0] D6 = 64'h7777_7777_7777_7777;
    localparam logic [63:0] K2 = 64'h0E32_9232_EA6D_0D73;
    localparam logic [63:0] D7 = 64'h8888_8888_8888_8888;
    localparam logic [63:0] K3 = 64'h9999_9999_9999_9999;

    logic        clk, rst, spi_cs_n, decrypt, key_reload, des_start, des_decrypt;
    logic        des_done, key_valid, busy, overrun, timeout_err;
    logic [63:0] spi_rx_word, spi_tx_word, des_key, des_din, des_dout;

    start_t      exp_start[$];
    logic [63:0] exp_tx[$];
    int          vectors = 0, miscompares = 0, cyc = 0;
    int          rise_cyc = 0, start_cyc = 0, tx_cyc = 0, done_cyc = 0, stub_delay = 0;
    logic [63:0] stub_val = '0, prev_tx = '0;
    bit          mon_en = 0;

    des_spi_ctrl #(.TIMEOUT_CYCLES(64), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .spi_cs_n    (spi_cs_n),
        .spi_rx_word (spi_rx_word),
        .spi_tx_word (spi_tx_word),
        .decrypt     (decrypt),
        .key_reload  (key_reload),
        .des_start   (des_start),
        .des_decrypt (des_decrypt),
        .des_key     (des_key),
        .des_din     (des_din),
        .des_dout    (des_dout),
        .des_done    (des_done),
        .key_valid   (key_valid),
        .busy        (busy),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // DES stub: answers each start after stub_delay cycles; 0 means never
    initial begin
        des_done = 0;
        des_dout = '0;
        forever begin
            @(negedge clk);
            if (mon_en && des_start === 1'b1 && stub_delay > 0) begin
                repeat (stub_delay - 1) @(negedge clk);
                des_dout = stub_val;
                des_done = 1;
                done_cyc = cyc + 1;
                @(negedge clk);
                des_done = 0;
            end
        end
    end

    // monitor: pops expectations whenever a start pulses or the tx word moves
    initial begin
        start_t      e;
        logic [63:0] t;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (des_start === 1'b1) begin
                    start_cyc = cyc;
                    vectors++;
                    if (exp_start.size() == 0) begin
                        miscompares++;
                        $display("FAIL start: unexpected des_start din=%h", des_din);
                    end else begin
                        e = exp_start.pop_front();
                        if ({des_din, des_decrypt, des_key} !== e) begin
                            miscompares++;
                            $display("FAIL start: got din=%h dec=%b key=%h expected din=%h dec=%b key=%h",
                                     des_din, des_decrypt, des_key, e.din, e.dec, e.key);
                        end
                    end
                end
                if (spi_tx_word !== prev_tx) begin
                    tx_cyc  = cyc;
                    prev_tx = spi_tx_word;
                    vectors++;
                    if (exp_tx.size() == 0) begin
                        miscompares++;
                        $display("FAIL tx: unexpected change to %h", spi_tx_word);
                    end else begin
                        t = exp_tx.pop_front();
                        if (spi_tx_word !== t) begin
                            miscompares++;
                            $display("FAIL tx: got %h expected %h", spi_tx_word, t);
                        end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_q(input int ns, input int nt, input int budget, input string name);
        int n = 0;
        while ((exp_start.size() > ns || exp_tx.size() > nt) && n < budget) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL %s: timed out with %0d starts and %0d tx words pending, expected %0d/%0d",
                     name, exp_start.size(), exp_tx.size(), ns, nt);
        end
    endtask

    task automatic frame(input logic [63:0] w, input logic dec, input int low);
        @(negedge clk);
        spi_cs_n = 0;
        repeat (low) @(negedge clk);
        spi_rx_word = w;
        decrypt     = dec;
        spi_cs_n    = 1;
        rise_cyc    = cyc;
    endtask

    function automatic start_t mk(input logic [63:0] din, input logic dec, input logic [63:0] key);
        return {din, dec, key};
    endfunction

    initial begin
        rst = 1; spi_cs_n = 1; spi_rx_word = '0; decrypt = 0; key_reload = 0;
        repeat (3) @(negedge clk);
        chk("reset_flags", 64'({des_start, des_decrypt, key_valid, busy, overrun, timeout_err}), 64'h0);
        chk("reset_tx", spi_tx_word, 64'h0);
        chk("reset_key", des_key, 64'h0);
        chk("reset_din", des_din, 64'h0);
        prev_tx = '0;
        mon_en  = 1;
        rst     = 0;

        frame(K1, 1'b0, 8);
        repeat (8) @(negedge clk);
        chk("key1_valid", 64'(key_valid), 64'h1);
        chk("key1_value", des_key, K1);
        chk("key1_tx", spi_tx_word, 64'h0);
        chk("key1_busy", 64'(busy), 64'h0);

        stub_delay = 16; stub_val = R1;
        exp_start.push_back(mk(D1, 1'b0, K1));
        exp_tx.push_back(R1);
        frame(D1, 1'b0, 8);
        wait_q(0, 1, 20, "start1");
        chk("start1_latency", 64'(start_cyc - rise_cyc), 64'd4);
        wait_q(0, 0, 40, "tx1");
        chk("tx1_latency", 64'(tx_cyc - done_cyc), 64'd1);

        stub_val = R2;
        exp_start.push_back(mk(D2, 1'b0, K1));
        exp_tx.push_back(R2);
        frame(D2, 1'b0, 8);
        wait_q(0, 1, 20, "start2");
        @(negedge clk);
        spi_cs_n = 0;
        repeat (24) @(negedge clk);
        chk("hold_tx", spi_tx_word, R1);
        chk("hold_busy", 64'(busy), 64'h1);
        stub_val = R3;
        exp_start.push_back(mk(D3, 1'b0, K1));
        exp_tx.push_back(R3);
        spi_rx_word = D3;
        spi_cs_n    = 1;
        rise_cyc    = cyc;
        wait_q(1, 1, 20, "tx2");
        chk("tx2_latency", 64'(tx_cyc - rise_cyc), 64'd3);
        wait_q(0, 1, 20, "start3");
        chk("start3_latency", 64'(start_cyc - rise_cyc), 64'd4);
        wait_q(0, 0, 40, "tx3");
        chk("no_overrun", 64'(overrun), 64'h0);

        stub_delay = 30; stub_val = R4;
        exp_start.push_back(mk(D4, 1'b0, K1));
        exp_tx.push_back(R4);
        frame(D4, 1'b0, 8);
        wait_q(0, 1, 20, "start4");
        frame(D5, 1'b0, 4);
        repeat (6) @(negedge clk);
        chk("overrun_set", 64'(overrun), 64'h1);
        chk("overrun_din", des_din, D4);
        chk("overrun_busy", 64'(busy), 64'h1);
        wait_q(0, 0, 60, "tx4");
        chk("overrun_idle", 64'(busy), 64'h0);

        stub_delay = 0;
        exp_start.push_back(mk(D6, 1'b0, K1));
        exp_tx.push_back(TIMEOUT_FILL);
        frame(D6, 1'b0, 8);
        wait_q(0, 1, 20, "start6");
        wait_q(0, 0, 100, "tx_timeout");
        chk("timeout_err", 64'(timeout_err), 64'h1);
        chk("timeout_latency", 64'(tx_cyc - start_cyc), 64'd66);
        chk("timeout_idle", 64'(busy), 64'h0);

        @(negedge clk);
        key_reload = 1;
        @(negedge clk);
        key_reload = 0;
        frame(K2, 1'b0, 8);
        repeat (8) @(negedge clk);
        chk("key2_value", des_key, K2);
        stub_delay = 40; stub_val = 64'hBAD0_BAD0_BAD0_BAD0;
        exp_start.push_back(mk(D7, 1'b1, K2));
        frame(D7, 1'b1, 8);
        wait_q(0, 0, 20, "start7");
        chk("start7_decrypt", 64'(des_decrypt), 64'h1);
        repeat (5) @(negedge clk);
        chk("busy7", 64'(busy), 64'h1);
        exp_tx.push_back(64'h0);
        rst = 1;
        @(negedge clk);
        chk("rst_flags", 64'({des_start, des_decrypt, key_valid, busy, overrun, timeout_err}), 64'h0);
        chk("rst_tx", spi_tx_word, 64'h0);
        chk("rst_key", des_key, 64'h0);
        chk("rst_din", des_din, 64'h0);
        rst = 0;
        wait_q(0, 0, 5, "tx_reset");
        frame(K3, 1'b0, 8);
        repeat (8) @(negedge clk);
        chk("key3_valid", 64'(key_valid), 64'h1);
        chk("key3_value", des_key, K3);
        repeat (50) @(negedge clk);
        chk("late_done_idle", 64'(busy), 64'h0);
        chk("late_done_tx", spi_tx_word, 64'h0);
        chk("queues_empty", 64'(exp_start.size() + exp_tx.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/des_spi_ctrl.md
Name: des_spi_ctrl

Overview:
- System-clock sequencer between the 64-bit SPI slave and the DES core.
- Detects the end of each SPI frame and classifies the received word as key or data.
- Starts the DES core on data frames and loads the result into the SPI slave's transmit word, so the result shifts out on the next frame.
- Provides overrun, timeout and status flags.

Parameters:
- TIMEOUT_CYCLES, 64: maximum clk cycles from des_start to des_done before an error is declared.
- SYNC_STAGES, 2: number of flops in the cs_n synchroniser (minimum 2).

Ports:
- clk  in  1  system clock; the only clock of this block.
- rst  in  1  synchronous, active-high reset.
- spi_cs_n  in  1  SPI chip select from the pad, asynchronous to clk.
- spi_rx_word  in  64  received word from the SPI slave; stable while spi_cs_n is high.
- spi_tx_word  out  64  transmit word to the SPI slave; changes only while synchronised cs_n is high.
- decrypt  in  1  mode for the next data frame (0 = encrypt, 1 = decrypt); sampled at capture.
- key_reload  in  1  one-cycle pulse; the next frame is treated as a key.
- des_start  out  1  one-cycle start pulse to the DES core.
- des_decrypt  out  1  mode to the DES core; held from start until done.
- des_key  out  64  key register.
- des_din  out  64  data block; held from start until done.
- des_dout  in  64  DES result; valid in the des_done cycle.
- des_done  in  1  one-cycle completion pulse.
- key_valid  out  1  a key has been loaded.
- busy  out  1  state is not S_IDLE.
- overrun  out  1  sticky: a frame ended while busy.
- timeout_err  out  1  sticky: DES core did not respond in time.

Behaviour:
- Reset (rst=1 at posedge clk):
  - All outputs 0; spi_tx_word = 64'h0.
  - State S_IDLE; key_pending = 1.
  - Synchroniser flops preset to 1.
- cs_rise: one-cycle strobe when the synchronised cs_n goes 0→1. It appears SYNC_STAGES+1 cycles after the pad edge.
- key_reload: sets key_pending on the next cycle.
  - If it coincides with a capture, it applies to the following frame.
- S_IDLE:
  - On cs_rise with key_pending=1: des_key <= spi_rx_word, key_valid <= 1, key_pending <= 0, stay in S_IDLE.
  - On cs_rise with key_pending=0: des_din <= spi_rx_word, des_decrypt <= decrypt, go to S_START.
- S_START:
  - des_start = 1 for exactly one cycle.
  - Clear the timeout counter; go to S_BUSY.
- S_BUSY:
  - Counter increments each cycle.
  - On des_done: result_reg <= des_dout, go to S_LOAD.
  - If the counter reaches TIMEOUT_CYCLES-1 with no done: timeout_err <= 1, result_reg <= 64'hFFFF_FFFF_FFFF_FFFF, go to S_LOAD.
  - If des_done and the timeout hit fall in the same cycle, done wins.
- S_LOAD:
  - If synchronised cs_n = 1: spi_tx_word <= result_reg, go to S_IDLE.
  - Otherwise wait in S_LOAD. spi_tx_word never changes mid-frame.
- Overrun:
  - A cs_rise in any state other than S_IDLE sets overrun=1.
  - That frame's word is discarded, including key frames.
  - The operation in flight is unaffected.
- Key frames never modify spi_tx_word. The master reads back the previous result or 0.
- Latency from pad cs_n rise to des_start: SYNC_STAGES+2 cycles.
- Latency from des_done to spi_tx_word update: 1 cycle when cs_n is high.
- Sticky flags (overrun, timeout_err) clear only on rst.
- Reset mid-operation: abort immediately; DES outputs are deasserted the next cycle.
- A late des_done arriving after reset or after a timeout is ignored when it is seen in S_IDLE.

Decomposition:
- Package des_ctrl_pkg holds:
  - state enum: S_IDLE, S_START, S_BUSY, S_LOAD;
  - DES_W = 64;
  - TIMEOUT_FILL = 64'hFFFF_FFFF_FFFF_FFFF.
- Sub-module sync_2ff (parameter SYNC_STAGES, preset value 1) synchronises spi_cs_n. Edge detection stays in the top level.

Test Plan:
- Reset, then a frame carrying 64'h1334_5779_9BBC_DFF1:
  - key_valid=1, des_key equals that value;
  - no des_start; spi_tx_word = 0.
- Next, a frame 64'h0123_4567_89AB_CDEF with decrypt=0 and a DES stub returning 64'h85E8_1354_0F0A_B405 after 16 cycles:
  - des_start pulses SYNC_STAGES+2 cycles after the cs_n rise;
  - spi_tx_word = 85E8_1354_0F0A_B405 one cycle after done.
- Hold spi_cs_n low when des_done arrives:
  - spi_tx_word stays unchanged and the state stays S_LOAD;
  - spi_tx_word updates one cycle after the synchronised cs_n returns high.
- End a second frame while busy:
  - overrun=1, des_din unchanged, a single des_start only;
  - the first result is still loaded.
- Stub never asserts des_done:
  - after 64 cycles timeout_err=1, spi_tx_word = all-ones, then return to S_IDLE.
- Pulse key_reload, send 64'h0E32_9232_EA6D_0D73, then a data frame with decrypt=1:
  - des_key is updated and des_decrypt=1 at des_start;
  - assert rst in S_BUSY: all outputs 0 the next cycle and key_pending=1.
